// File: rtl/voice_scheduler_pkg.sv
// rtl/voice_scheduler_pkg.sv - shared definitions for the chord voice scheduler
// Purpose: scheduler state encoding, voice count and default bus widths.
// Ports: none (package).
package voice_scheduler_pkg;

  localparam int NUM_VOICES = 3;
  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 6;

  typedef enum logic [1:0] {
    SCHED_WAIT    = 2'd0,
    SCHED_STALL   = 2'd1,
    SCHED_ADVANCE = 2'd2,
    SCHED_ACK     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - song_reader entry handshake and voice load bus
// Purpose: groups the entry handshake from song_reader and the shared voice bus.
// Signals:
//   new_note/note_in/duration_in/advance_in : entry offered by song_reader
//   note_done                               : request for the next entry
//   load_voice/note_out/duration_out         : one-hot load and shared note bus
//   voice_busy                              : per-voice occupancy
//   voice_done                              : per-voice done_with_note pulses
// Modports: master = song_reader + voices side, slave = scheduler.
interface voice_scheduler_if
  import voice_scheduler_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
);
  logic                  new_note;
  logic [NOTE_W-1:0]     note_in;
  logic [DUR_W-1:0]      duration_in;
  logic                  advance_in;
  logic                  note_done;
  logic [NUM_VOICES-1:0] load_voice;
  logic [NOTE_W-1:0]     note_out;
  logic [DUR_W-1:0]      duration_out;
  logic [NUM_VOICES-1:0] voice_busy;
  logic [NUM_VOICES-1:0] voice_done;

  modport master (
    output new_note, note_in, duration_in, advance_in, voice_done,
    input  note_done, load_voice, note_out, duration_out, voice_busy
  );

  modport slave (
    input  new_note, note_in, duration_in, advance_in, voice_done,
    output note_done, load_voice, note_out, duration_out, voice_busy
  );
endinterface

// File: rtl/voice_scheduler_picker.sv
// rtl/voice_scheduler_picker.sv - lowest-index free voice priority encoder
// Purpose: one-hot grant of the lowest set bit of the free vector.
// Ports:
//   free_i  : voices available this cycle
//   grant_o : one-hot grant (zero when nothing is free)
//   any_o   : at least one voice is free
module voice_picker
  import voice_scheduler_pkg::*;
(
  input  logic [NUM_VOICES-1:0] free_i,
  output logic [NUM_VOICES-1:0] grant_o,
  output logic                  any_o
);
  // x & -x isolates the lowest set bit.
  assign grant_o = free_i & (~free_i + NUM_VOICES'(1));
  assign any_o   = |free_i;
endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - allocates song entries to three note voices
// Purpose: accepts one entry at a time, loads notes into free voices, stalls
// while all voices are busy, counts beats for time-advance entries and pulses
// note_done when the next entry may be fetched.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   play_i         : low freezes scheduling (busy clearing continues)
//   beat_i         : one-cycle beat pulse
//   bus            : entry handshake and voice bus (slave side)
//   protocol_err_o : sticky, new_note seen outside WAIT
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            play_i,
  input  logic            beat_i,
  voice_scheduler_if.slave bus,
  output logic            protocol_err_o
);

  sched_state_e          state_q, state_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [DUR_W-1:0]      count_q, count_d;
  logic [NOTE_W-1:0]     ent_note_q, ent_note_d;
  logic [DUR_W-1:0]      ent_dur_q, ent_dur_d;
  logic                  ent_adv_q, ent_adv_d;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NOTE_W-1:0]     note_out_q, note_out_d;
  logic [DUR_W-1:0]      dur_out_q, dur_out_d;
  logic                  perr_q, perr_d;

  logic [NUM_VOICES-1:0] free;
  logic [NUM_VOICES-1:0] grant;
  logic                  any_free;

  // A voice finishing this cycle may be reloaded on the same edge.
  assign free = ~busy_q | bus.voice_done;

  voice_picker u_picker (
    .free_i  (free),
    .grant_o (grant),
    .any_o   (any_free)
  );

  logic              take;
  logic [NOTE_W-1:0] e_note;
  logic [DUR_W-1:0]  e_dur;
  logic              e_adv;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q & ~bus.voice_done;
    count_d    = count_q;
    ent_note_d = ent_note_q;
    ent_dur_d  = ent_dur_q;
    ent_adv_d  = ent_adv_q;
    load_d     = '0;
    note_out_d = note_out_q;
    dur_out_d  = dur_out_q;
    perr_d     = perr_q | (bus.new_note && (state_q != SCHED_WAIT));
    take       = 1'b0;
    e_note     = ent_note_q;
    e_dur      = ent_dur_q;
    e_adv      = ent_adv_q;

    unique case (state_q)
      SCHED_WAIT: begin
        if (bus.new_note) begin
          ent_note_d = bus.note_in;
          ent_dur_d  = bus.duration_in;
          ent_adv_d  = bus.advance_in;
          if (play_i) begin
            take   = 1'b1;
            e_note = bus.note_in;
            e_dur  = bus.duration_in;
            e_adv  = bus.advance_in;
          end else begin
            // Held entry is replayed from STALL once play returns.
            state_d = SCHED_STALL;
          end
        end
      end
      SCHED_STALL: begin
        if (play_i) take = 1'b1;
      end
      SCHED_ADVANCE: begin
        if (play_i && beat_i) begin
          if (count_q == DUR_W'(1)) begin
            count_d = '0;
            state_d = SCHED_ACK;
          end else begin
            count_d = count_q - DUR_W'(1);
          end
        end
      end
      SCHED_ACK: begin
        state_d = SCHED_WAIT;
      end
      default: state_d = SCHED_WAIT;
    endcase

    if (take) begin
      if (e_adv) begin
        if (e_dur == '0) begin
          state_d = SCHED_ACK;
        end else begin
          count_d = e_dur;
          state_d = SCHED_ADVANCE;
        end
      end else if (e_note == '0) begin
        state_d = SCHED_ACK;
      end else if (any_free) begin
        load_d     = grant;
        note_out_d = e_note;
        dur_out_d  = e_dur;
        state_d    = SCHED_ACK;
      end else begin
        state_d = SCHED_STALL;
      end
    end

    // Load wins over a same-edge done on the same voice.
    busy_d = busy_d | load_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCHED_WAIT;
      busy_q     <= '0;
      count_q    <= '0;
      ent_note_q <= '0;
      ent_dur_q  <= '0;
      ent_adv_q  <= 1'b0;
      load_q     <= '0;
      note_out_q <= '0;
      dur_out_q  <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      ent_note_q <= ent_note_d;
      ent_dur_q  <= ent_dur_d;
      ent_adv_q  <= ent_adv_d;
      load_q     <= load_d;
      note_out_q <= note_out_d;
      dur_out_q  <= dur_out_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.note_done    = (state_q == SCHED_ACK);
  assign bus.load_voice   = load_q;
  assign bus.note_out     = note_out_q;
  assign bus.duration_out = dur_out_q;
  assign bus.voice_busy   = busy_q;
  assign protocol_err_o   = perr_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
module tb_voice_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic play;
  logic beat;
  logic perr;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  voice_scheduler_if #(.NOTE_W(6), .DUR_W(6)) bus ();

  voice_scheduler #(.NOTE_W(6), .DUR_W(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .play_i         (play),
    .beat_i         (beat),
    .bus            (bus.slave),
    .protocol_err_o (perr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] note, input logic [5:0] dur, input logic adv);
    bus.new_note    = 1'b1;
    bus.note_in     = note;
    bus.duration_in = dur;
    bus.advance_in  = adv;
    tick();
    bus.new_note    = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    play            = 1'b0;
    beat            = 1'b0;
    bus.new_note    = 1'b0;
    bus.note_in     = '0;
    bus.duration_in = '0;
    bus.advance_in  = 1'b0;
    bus.voice_done  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_note_done", 32'(bus.note_done), 32'd0);
    check("rst_load", 32'(bus.load_voice), 32'd0);
    check("rst_busy", 32'(bus.voice_busy), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_note_out", 32'(bus.note_out), 32'd0);
    check("rst_dur_out", 32'(bus.duration_out), 32'd0);

    // Chord fill
    play = 1'b1;
    send(6'd20, 6'd4, 1'b0);
    check("chord1_load", 32'(bus.load_voice), 32'b001);
    check("chord1_done", 32'(bus.note_done), 32'd1);
    check("chord1_note", 32'(bus.note_out), 32'd20);
    check("chord1_dur", 32'(bus.duration_out), 32'd4);
    check("chord1_busy", 32'(bus.voice_busy), 32'b001);
    tick();
    check("chord1_load_clr", 32'(bus.load_voice), 32'd0);
    check("chord1_done_clr", 32'(bus.note_done), 32'd0);
    send(6'd24, 6'd4, 1'b0);
    check("chord2_load", 32'(bus.load_voice), 32'b010);
    check("chord2_note", 32'(bus.note_out), 32'd24);
    tick();
    send(6'd27, 6'd4, 1'b0);
    check("chord3_load", 32'(bus.load_voice), 32'b100);
    check("chord3_note", 32'(bus.note_out), 32'd27);
    check("chord3_busy", 32'(bus.voice_busy), 32'b111);
    tick();

    // Stall until voice 1 finishes
    send(6'd30, 6'd5, 1'b0);
    check("stall_done", 32'(bus.note_done), 32'd0);
    check("stall_load", 32'(bus.load_voice), 32'd0);
    tick();
    check("stall_hold", 32'(bus.note_done), 32'd0);
    bus.voice_done = 3'b010;
    tick();
    bus.voice_done = 3'b000;
    check("release_load", 32'(bus.load_voice), 32'b010);
    check("release_note", 32'(bus.note_out), 32'd30);
    check("release_done", 32'(bus.note_done), 32'd1);
    check("release_busy", 32'(bus.voice_busy), 32'b111);
    tick();

    // Free voice 2, then same-edge done on voice 0 with a new note
    bus.voice_done = 3'b100;
    tick();
    bus.voice_done = 3'b000;
    check("free2_busy", 32'(bus.voice_busy), 32'b011);
    bus.voice_done = 3'b001;
    send(6'd33, 6'd2, 1'b0);
    bus.voice_done = 3'b000;
    check("same_edge_load", 32'(bus.load_voice), 32'b001);
    check("same_edge_busy", 32'(bus.voice_busy), 32'b011);
    tick();

    // Rest and zero-length advance
    send(6'd0, 6'd7, 1'b0);
    check("rest_done", 32'(bus.note_done), 32'd1);
    check("rest_load", 32'(bus.load_voice), 32'd0);
    check("rest_note_hold", 32'(bus.note_out), 32'd33);
    tick();
    send(6'd9, 6'd0, 1'b1);
    check("adv0_done", 32'(bus.note_done), 32'd1);
    check("adv0_load", 32'(bus.load_voice), 32'd0);
    tick();

    // Entry arriving with play low is held, not dropped
    play = 1'b0;
    send(6'd40, 6'd1, 1'b0);
    check("paused_done", 32'(bus.note_done), 32'd0);
    check("paused_load", 32'(bus.load_voice), 32'd0);
    play = 1'b1;
    tick();
    check("resume_load", 32'(bus.load_voice), 32'b100);
    check("resume_note", 32'(bus.note_out), 32'd40);
    check("resume_done", 32'(bus.note_done), 32'd1);
    tick();
    check("pre_adv_perr", 32'(perr), 32'd0);

    // Advance by 3 beats, with a paused beat and a stray new_note
    send(6'd0, 6'd3, 1'b1);
    check("adv_start_done", 32'(bus.note_done), 32'd0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    play = 1'b0;
    beat = 1'b1;
    tick();
    beat = 1'b0;
    play = 1'b1;
    send(6'd50, 6'd9, 1'b0);
    check("adv_perr", 32'(perr), 32'd1);
    check("adv_no_load", 32'(bus.load_voice), 32'd0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    check("adv_beat2_done", 32'(bus.note_done), 32'd0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    check("adv_beat3_done", 32'(bus.note_done), 32'd1);
    tick();
    check("adv_done_clr", 32'(bus.note_done), 32'd0);

    // Reset in the middle of an advance
    send(6'd0, 6'd5, 1'b1);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_done", 32'(bus.note_done), 32'd0);
    check("mid_rst_load", 32'(bus.load_voice), 32'd0);
    check("mid_rst_busy", 32'(bus.voice_busy), 32'd0);
    check("mid_rst_perr", 32'(perr), 32'd0);
    check("mid_rst_note", 32'(bus.note_out), 32'd0);
    check("mid_rst_dur", 32'(bus.duration_out), 32'd0);
    send(6'd0, 6'd1, 1'b0);
    check("post_rst_wait", 32'(bus.note_done), 32'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
